// File: rtl/amstrad_wait_seq_if.sv
// Bus bundle between the CPU-side timing logic and the wait sequencer:
// clock-enable/handshake inputs and the wait, enable and statistics outputs.
interface amstrad_wait_seq_if #(
    parameter int PH_W  = 2,
    parameter int CNT_W = 16
);
    logic             ce_4p;
    logic             no_wait;
    logic             phase_sync;
    logic             mreq_n;
    logic             iorq_n;
    logic             rfsh_n;
    logic             stat_clr;
    logic             wait_n;
    logic             cpu_ce;
    logic             cyc_1m;
    logic             vid_ce;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output ce_4p, no_wait, phase_sync, mreq_n, iorq_n, rfsh_n, stat_clr,
        input  wait_n, cpu_ce, cyc_1m, vid_ce, phase, wait_cnt
    );

    modport slave (
        input  ce_4p, no_wait, phase_sync, mreq_n, iorq_n, rfsh_n, stat_clr,
        output wait_n, cpu_ce, cyc_1m, vid_ce, phase, wait_cnt
    );
endinterface

// File: rtl/amstrad_wait_seq.sv
// Gate-array style CPU wait sequencer: stretches each CPU access so it is
// released on a fixed bus phase, with optional extra periods for IO cycles.
module amstrad_wait_seq #(
    parameter int               PERIOD        = 4,
    parameter int               RELEASE_PHASE = 0,
    parameter int               IO_EXTRA      = 0,
    parameter logic [PERIOD-1:0] VID_MASK     = 4'b1010,
    parameter int               CNT_W         = 16
) (
    input logic               clk,
    input logic               reset,
    amstrad_wait_seq_if.slave bus
);
    localparam int              PH_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] PH_REL    = PH_W'(RELEASE_PHASE);
    localparam logic [2:0]      XLOAD     = 3'(IO_EXTRA);
    localparam logic            IO_EXT_EN = (IO_EXTRA != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_IOWAIT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [PH_W-1:0]  phase_r;
    logic [2:0]       xcnt_r;
    logic [2:0]       xcnt_s;
    logic             old_acc_r;
    logic             wait_n_r;
    logic             wait_n_s;
    logic [CNT_W-1:0] wait_cnt_r;

    logic acc_s;
    logic is_io_s;
    logic io_ext_s;
    logic start_s;
    logic at_rel_s;

    assign acc_s    = (~bus.mreq_n & bus.rfsh_n) | ~bus.iorq_n;
    assign is_io_s  = ~bus.iorq_n;
    assign io_ext_s = is_io_s & IO_EXT_EN;
    assign start_s  = bus.ce_4p & acc_s & ~old_acc_r;
    assign at_rel_s = (phase_r == PH_REL);

    // Phase counter: free-running on ce_4p, resynchronised only on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= '0;
        end else if (bus.ce_4p) begin
            if (bus.phase_sync || (phase_r == PH_LAST)) begin
                phase_r <= '0;
            end else begin
                phase_r <= phase_r + PH_W'(1);
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // Access edge detector, sampled only on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_acc_r <= 1'b0;
        end else if (bus.ce_4p) begin
            old_acc_r <= acc_s;
        end else begin
            old_acc_r <= old_acc_r;
        end
    end

    // Next-state logic; a dropped access aborts a wait ahead of the release check.
    always_comb begin
        state_s = state_r;
        xcnt_s  = xcnt_r;
        if (bus.no_wait) begin
            state_s = S_IDLE;
        end else if (bus.ce_4p) begin
            case (state_r)
                S_IDLE: begin
                    if (!start_s) begin
                        state_s = S_IDLE;
                    end else if (!at_rel_s) begin
                        state_s = S_WAIT;
                    end else if (io_ext_s) begin
                        state_s = S_IOWAIT;
                        xcnt_s  = XLOAD;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (!acc_s) begin
                        state_s = S_IDLE;
                    end else if (!at_rel_s) begin
                        state_s = S_WAIT;
                    end else if (io_ext_s) begin
                        state_s = S_IOWAIT;
                        xcnt_s  = XLOAD;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_IOWAIT: begin
                    if (!acc_s) begin
                        state_s = S_IDLE;
                    end else if (at_rel_s) begin
                        xcnt_s = xcnt_r - 3'd1;
                        if (xcnt_r == 3'd1) begin
                            state_s = S_HOLD;
                        end else begin
                            state_s = S_IOWAIT;
                        end
                    end else begin
                        state_s = S_IOWAIT;
                    end
                end
                S_HOLD: begin
                    if (!acc_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        wait_n_s = ~((state_s == S_WAIT) || (state_s == S_IOWAIT));
    end

    // FSM, extra-period counter and registered wait output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            xcnt_r   <= 3'd0;
            wait_n_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            xcnt_r   <= xcnt_s;
            wait_n_r <= wait_n_s;
        end
    end

    // Saturating count of ticks the CPU spent stalled.
    always_ff @(posedge clk) begin
        if (reset || bus.stat_clr) begin
            wait_cnt_r <= '0;
        end else if (bus.ce_4p && !wait_n_r && !(&wait_cnt_r)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign bus.wait_n   = wait_n_r;
    assign bus.cpu_ce   = bus.ce_4p & wait_n_r;
    assign bus.cyc_1m   = (phase_r == PH_LAST);
    assign bus.vid_ce   = bus.ce_4p & VID_MASK[phase_r];
    assign bus.phase    = phase_r;
    assign bus.wait_cnt = wait_cnt_r;
endmodule

// File: tb/tb_amstrad_wait_seq.sv
// Directed scoreboard bench: u0 uses default parameters, u1 uses IO_EXTRA=2
// and a 4-bit counter; both see the same stimulus.
module tb_amstrad_wait_seq;
    logic clk;
    logic reset;
    logic ce;
    logic no_wait;
    logic phase_sync;
    logic mreq_n;
    logic iorq_n;
    logic rfsh_n;
    logic stat_clr;

    int n_assert;
    int n_fail;
    int cnt;
    logic [1:0] ph;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    amstrad_wait_seq_if #(.PH_W(2), .CNT_W(16)) bus0 ();
    amstrad_wait_seq_if #(.PH_W(2), .CNT_W(4))  bus1 ();

    assign bus0.ce_4p      = ce;
    assign bus0.no_wait    = no_wait;
    assign bus0.phase_sync = phase_sync;
    assign bus0.mreq_n     = mreq_n;
    assign bus0.iorq_n     = iorq_n;
    assign bus0.rfsh_n     = rfsh_n;
    assign bus0.stat_clr   = stat_clr;
    assign bus1.ce_4p      = ce;
    assign bus1.no_wait    = no_wait;
    assign bus1.phase_sync = phase_sync;
    assign bus1.mreq_n     = mreq_n;
    assign bus1.iorq_n     = iorq_n;
    assign bus1.rfsh_n     = rfsh_n;
    assign bus1.stat_clr   = stat_clr;

    amstrad_wait_seq u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    amstrad_wait_seq #(
        .PERIOD        (4),
        .RELEASE_PHASE (0),
        .IO_EXTRA      (2),
        .VID_MASK      (4'b1010),
        .CNT_W         (4)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    function automatic void expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endfunction

    task automatic check_out(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d, no expectation queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic tick_begin();
        ce = 1'b1;
        #1;
    endtask

    task automatic tick_end();
        @(posedge clk);
        #1;
        ph = phase_sync ? 2'd0 : ph + 2'd1;
        ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_begin();
        tick_end();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ce         = 1'b0;
        no_wait    = 1'b0;
        phase_sync = 1'b0;
        mreq_n     = 1'b1;
        iorq_n     = 1'b1;
        rfsh_n     = 1'b1;
        stat_clr   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ph    = 2'd0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        ph       = 2'd0;
        do_reset();

        // reset state
        expect_val("rst_phase", 32'd0);
        expect_val("rst_wait_n", 32'd1);
        expect_val("rst_wait_cnt", 32'd0);
        expect_val("rst_cyc_1m", 32'd0);
        expect_val("rst_cpu_ce", 32'd0);
        check_out(32'(bus0.phase));
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.wait_cnt));
        check_out(32'(bus0.cyc_1m));
        check_out(32'(bus0.cpu_ce));

        // MREQ start at phase 2: two wait ticks, released on phase 0
        tick();
        tick();
        mreq_n = 1'b0;
        expect_val("a_wait_n_start", 32'd0);
        expect_val("a_phase", 32'd3);
        tick();
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.phase));
        expect_val("a_wait_n_ph3", 32'd0);
        expect_val("a_cnt_ph3", 32'd1);
        tick();
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.wait_cnt));
        expect_val("a_wait_n_rel", 32'd1);
        expect_val("a_cnt_rel", 32'd2);
        tick();
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.wait_cnt));

        // aligned MREQ start: straight to hold, no wait, and no restart in hold
        do_reset();
        mreq_n = 1'b0;
        expect_val("b_wait_n_aligned", 32'd1);
        tick();
        check_out(32'(bus0.wait_n));
        mreq_n = 1'b1;
        #2;
        mreq_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_val("b_hold_wait_n", 32'd1);
            tick();
            expect_val("b_cyc_1m", (ph == 2'd3) ? 32'd1 : 32'd0);
            check_out(32'(bus0.wait_n));
            check_out(32'(bus0.cyc_1m));
        end
        expect_val("b_cnt", 32'd0);
        check_out(32'(bus0.wait_cnt));

        // IORQ start at phase 1 with two extra periods on u1
        do_reset();
        tick();
        iorq_n = 1'b0;
        expect_val("c_u1_wait_n_start", 32'd0);
        expect_val("c_u0_wait_n_start", 32'd0);
        tick();
        check_out(32'(bus1.wait_n));
        check_out(32'(bus0.wait_n));
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (bus1.wait_n == 1'b1) break;
            tick();
            cnt++;
        end
        expect_val("c_io_wait_ticks", 32'd11 + 32'd1);
        expect_val("c_u1_cnt", 32'd11);
        expect_val("c_u0_cnt", 32'd3);
        expect_val("c_u1_phase", 32'd1);
        check_out(32'(cnt));
        check_out(32'(bus1.wait_cnt));
        check_out(32'(bus0.wait_cnt));
        check_out(32'(bus1.phase));

        // aligned IO start: u1 goes straight to IO wait, u0 to hold
        iorq_n = 1'b1;
        tick();
        tick();
        tick();
        iorq_n = 1'b0;
        expect_val("c_u1_aligned_wait_n", 32'd0);
        expect_val("c_u0_aligned_wait_n", 32'd1);
        tick();
        check_out(32'(bus1.wait_n));
        check_out(32'(bus0.wait_n));
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus1.wait_n == 1'b1) break;
            tick();
            cnt++;
        end
        expect_val("c_aligned_ticks", 32'd8);
        expect_val("c_u1_cnt_sat", 32'd15);
        expect_val("c_u0_cnt_keep", 32'd3);
        check_out(32'(cnt));
        check_out(32'(bus1.wait_cnt));
        check_out(32'(bus0.wait_cnt));

        // stat_clr on a wait tick beats the increment; dropped access aborts wait
        iorq_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        iorq_n = 1'b0;
        tick();
        stat_clr = 1'b1;
        expect_val("d_clr_cnt", 32'd0);
        expect_val("d_clr_wait_n", 32'd0);
        tick();
        stat_clr = 1'b0;
        check_out(32'(bus1.wait_cnt));
        check_out(32'(bus1.wait_n));
        iorq_n = 1'b1;
        expect_val("d_abort_wait_n", 32'd1);
        expect_val("d_abort_phase", 32'd0);
        tick();
        check_out(32'(bus1.wait_n));
        check_out(32'(bus1.phase));

        // no_wait: never stalls, phase keeps running, video/period markers
        do_reset();
        no_wait = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mreq_n = (ph == 2'd2 || ph == 2'd3) ? 1'b0 : 1'b1;
            tick_begin();
            expect_val("e_vid_ce", (ph == 2'd1 || ph == 2'd3) ? 32'd1 : 32'd0);
            expect_val("e_cyc_1m", (ph == 2'd3) ? 32'd1 : 32'd0);
            expect_val("e_cpu_ce", 32'd1);
            expect_val("e_wait_n", 32'd1);
            check_out(32'(bus0.vid_ce));
            check_out(32'(bus0.cyc_1m));
            check_out(32'(bus0.cpu_ce));
            check_out(32'(bus0.wait_n));
            tick_end();
        end
        expect_val("e_phase_run", 32'd0);
        expect_val("e_cnt", 32'd0);
        check_out(32'(bus0.phase));
        check_out(32'(bus0.wait_cnt));
        no_wait = 1'b0;
        mreq_n  = 1'b1;

        // phase_sync only acts together with ce_4p
        tick();
        phase_sync = 1'b1;
        @(posedge clk);
        #1;
        expect_val("f_sync_no_ce", 32'd1);
        check_out(32'(bus0.phase));
        tick();
        phase_sync = 1'b0;
        expect_val("f_sync_ce", 32'd0);
        check_out(32'(bus0.phase));

        // phase_sync during wait: release on the resynchronised phase 0
        do_reset();
        tick();
        mreq_n = 1'b0;
        expect_val("g_wait_n_start", 32'd0);
        tick();
        check_out(32'(bus0.wait_n));
        phase_sync = 1'b1;
        expect_val("g_wait_n_synced", 32'd0);
        expect_val("g_phase_synced", 32'd0);
        tick();
        phase_sync = 1'b0;
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.phase));
        expect_val("g_wait_n_rel", 32'd1);
        expect_val("g_cnt", 32'd2);
        tick();
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.wait_cnt));

        // reset during a wait, with ce_4p high at the same time
        mreq_n = 1'b1;
        tick();
        mreq_n = 1'b0;
        expect_val("h_wait_n_pre", 32'd0);
        tick();
        check_out(32'(bus0.wait_n));
        reset = 1'b1;
        ce    = 1'b1;
        @(posedge clk);
        #1;
        expect_val("h_wait_n", 32'd1);
        expect_val("h_phase", 32'd0);
        expect_val("h_cnt", 32'd0);
        expect_val("h_u1_cnt", 32'd0);
        check_out(32'(bus0.wait_n));
        check_out(32'(bus0.phase));
        check_out(32'(bus0.wait_cnt));
        check_out(32'(bus1.wait_cnt));
        reset  = 1'b0;
        ce     = 1'b0;
        mreq_n = 1'b1;
        ph     = 2'd0;

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
